// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 serial RAM responder (READ 0x03 / WRITE 0x02) with backdoor preload
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_clk_i         SCK from master (mode 0, idle low)
//   spi_cs_i          chip select, active low
//   spi_data_i        MOSI
//   spi_data_o        MISO, driven only during the read data phase
//   busy_o            high while the synchronized chip select is asserted
//   cmd_err_o         one-cycle pulse when an unsupported command byte completes
//   bd_we_i           backdoor write strobe, honoured only while idle
//   bd_addr_i         backdoor address
//   bd_data_i         backdoor data
`timescale 1ns/1ps

module spi_ram_responder #(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_data_i,
    output logic              spi_data_o,
    output logic              busy_o,
    output logic              cmd_err_o,
    input  logic              bd_we_i,
    input  logic [ADDR_W-1:0] bd_addr_i,
    input  logic [7:0]        bd_data_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_t;

    state_t state;

    // Two synchronizer flops per pin; the third flop on SCK/CS gives the edge reference.
    logic [2:0] sclk_s;
    logic [2:0] cs_s;
    logic [1:0] mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 3'b000;
            cs_s   <= 3'b111;  // idle-high so reset release never looks like a CS edge
            mosi_s <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], spi_clk_i};
            cs_s   <= {cs_s[1:0], spi_cs_i};
            mosi_s <= {mosi_s[0], spi_data_i};
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic mosi_bit;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign mosi_bit  = mosi_s[1];

    logic [4:0]        bit_cnt;
    logic [22:0]       shift_in;
    logic [23:0]       shift_next;
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        tx_sr;
    logic              load_tx;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [7:0]        mem_rdata;

    assign shift_next = {shift_in, mosi_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            is_read    <= 1'b0;
            addr       <= '0;
            tx_sr      <= '0;
            load_tx    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            spi_data_o <= 1'b0;
            busy_o     <= 1'b0;
            cmd_err_o  <= 1'b0;
        end else begin
            cmd_err_o <= 1'b0;
            load_tx   <= 1'b0;
            wr_en_q   <= 1'b0;

            // Preload lands one clk after the address settles, long before the next SCK fall.
            if (load_tx) begin
                tx_sr <= mem_rdata;
            end

            if (cs_rise) begin
                // Any partial byte is simply dropped; nothing is committed.
                state      <= ST_IDLE;
                bit_cnt    <= '0;
                busy_o     <= 1'b0;
                spi_data_o <= 1'b0;
            end else if (cs_fall) begin
                state      <= ST_CMD;
                bit_cnt    <= '0;
                busy_o     <= 1'b1;
                spi_data_o <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift_in <= shift_next[22:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (shift_next[7:0])
                                    8'h03: begin
                                        is_read <= 1'b1;
                                        state   <= ST_ADDR;
                                    end
                                    8'h02: begin
                                        is_read <= 1'b0;
                                        state   <= ST_ADDR;
                                    end
                                    default: begin
                                        state     <= ST_IGNORE;
                                        cmd_err_o <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            shift_in <= shift_next[22:0];
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                addr    <= shift_next[ADDR_W-1:0];
                                if (is_read) begin
                                    load_tx <= 1'b1;
                                    state   <= ST_RD;
                                end else begin
                                    state   <= ST_WR;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_RD: begin
                        if (sclk_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                addr    <= addr + ADDR_W'(1);
                                load_tx <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (sclk_fall) begin
                            spi_data_o <= tx_sr[7];
                            tx_sr      <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    ST_WR: begin
                        if (sclk_rise) begin
                            shift_in <= shift_next[22:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr;
                                wr_data_q <= shift_next[7:0];
                                addr      <= addr + ADDR_W'(1);
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        // ST_IDLE and ST_IGNORE: hold until CS changes.
                    end
                endcase
            end
        end
    end

    // Backdoor is locked out from the very cycle CS is seen falling.
    logic              bd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    assign bd_ok     = bd_we_i & ~busy_o & ~cs_fall;
    assign mem_we    = wr_en_q | bd_ok;
    assign mem_waddr = wr_en_q ? wr_addr_q : bd_addr_i;
    assign mem_wdata = wr_en_q ? wr_data_q : bd_data_i;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    assign mem_rdata = mem[addr];

    generate
        if (INIT_ZERO) begin : g_mem_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < (1 << ADDR_W); i++) begin
                        mem[i] <= '0;
                    end
                end else if (mem_we) begin
                    mem[mem_waddr] <= mem_wdata;
                end
            end
        end else begin : g_mem_keep
            always_ff @(posedge clk) begin
                if (mem_we) begin
                    mem[mem_waddr] <= mem_wdata;
                end
            end
        end
    endgenerate

endmodule
